// File: rtl/internal_node_pkg.sv
// Shared defaults, count-width helper and sender FSM encoding for the internal-node sender.
package internal_node_pkg;

  localparam int DEF_INTERNAL_WIDTH = 22;
  localparam int DEF_NUM_NODES      = 127;
  localparam int DEF_MEM_ADDR_WIDTH = 7;

  // Wide enough to hold the value NUM_NODES itself, not just NUM_NODES-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_NUM_NODES);

  typedef enum logic [1:0] {
    IDLE,
    PAD,
    STREAM,
    DONE
  } sender_state_t;

endpackage

// File: rtl/internal_node_sender_if.sv
// Control, node-storage read port and tree write stream of the internal-node sender.
// The checksum signal exists only when INTERNAL_NODE_SENDER_CHECKSUM_EN is defined.
interface internal_node_sender_if
  import internal_node_pkg::*;
#(
  parameter int INTERNAL_WIDTH = DEF_INTERNAL_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
);
  logic                      start;
  logic                      abort;
  logic                      mem_ren;
  logic [MEM_ADDR_WIDTH-1:0] mem_raddr;
  logic [INTERNAL_WIDTH-1:0] mem_rdata;
  logic                      receiver_ready;
  logic                      sender_enable;
  logic [INTERNAL_WIDTH-1:0] sender_data;
  logic                      busy;
  logic                      done;
`ifdef INTERNAL_NODE_SENDER_CHECKSUM_EN
  logic [INTERNAL_WIDTH-1:0] checksum;

  modport master (
    input  start, abort, mem_rdata, receiver_ready,
    output mem_ren, mem_raddr, sender_enable, sender_data, busy, done, checksum
  );
  modport slave (
    output start, abort, mem_rdata, receiver_ready,
    input  mem_ren, mem_raddr, sender_enable, sender_data, busy, done, checksum
  );
`else
  modport master (
    input  start, abort, mem_rdata, receiver_ready,
    output mem_ren, mem_raddr, sender_enable, sender_data, busy, done
  );
  modport slave (
    output start, abort, mem_rdata, receiver_ready,
    input  mem_ren, mem_raddr, sender_enable, sender_data, busy, done
  );
`endif
endinterface

// File: rtl/sender_skid_fifo.sv
// Two-entry prefetch FIFO: registered storage, head visible combinationally on rdata.
// Simultaneous push and pop are both honoured, including when full; flush empties it.
module sender_skid_fifo #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [0:1];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/internal_node_sender.sv
// Streams a zero pad word then NUM_NODES node words to the tree, one per cycle when ready is high.
// Optional INTERNAL_NODE_SENDER_CHECKSUM_EN adds a running XOR of transferred node words.
module internal_node_sender
  import internal_node_pkg::*;
#(
  parameter int INTERNAL_WIDTH = DEF_INTERNAL_WIDTH,
  parameter int NUM_NODES      = DEF_NUM_NODES,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  internal_node_sender_if.master bus
);
  localparam int CNT_W = cnt_width(NUM_NODES);

  sender_state_t             state;
  logic [CNT_W-1:0]          rd_cnt;
  logic [CNT_W-1:0]          xfer_cnt;
  logic [MEM_ADDR_WIDTH-1:0] raddr;
  logic                      inflight;
  logic                      busy_q;
  logic                      done_q;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_flush;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [1:0]                fifo_count;
  logic [INTERNAL_WIDTH-1:0] fifo_head;
  logic [INTERNAL_WIDTH-1:0] head_dat;
  logic                      head_vld;
  logic                      issue;
  logic                      xfer;
  logic                      stream_xfer;
  logic                      last_xfer;

  // Read data landing into an empty FIFO is presented directly so node0 follows the pad.
  assign head_vld    = !fifo_empty || inflight;
  assign head_dat    = fifo_empty ? bus.mem_rdata : fifo_head;

  assign issue       = ((state == PAD) || (state == STREAM)) && !fifo_full &&
                       ((fifo_count + {1'b0, inflight}) < 2'd2) &&
                       (rd_cnt < CNT_W'(NUM_NODES));

  assign bus.sender_enable = (state == PAD) || ((state == STREAM) && head_vld);
  assign bus.sender_data   = ((state == STREAM) && head_vld) ? head_dat : '0;
  assign bus.mem_ren       = issue;
  assign bus.mem_raddr     = raddr;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

  assign xfer        = bus.sender_enable && bus.receiver_ready;
  assign stream_xfer = xfer && (state == STREAM);
  assign last_xfer   = stream_xfer && (xfer_cnt == CNT_W'(NUM_NODES - 1));
  assign fifo_flush  = bus.abort && (state != IDLE);
  assign fifo_push   = inflight && !(fifo_empty && stream_xfer);
  assign fifo_pop    = stream_xfer && !fifo_empty;

  sender_skid_fifo #(.WIDTH(INTERNAL_WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (bus.mem_rdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      xfer_cnt <= '0;
      raddr    <= '0;
      inflight <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (fifo_flush) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      xfer_cnt <= '0;
      raddr    <= '0;
      inflight <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
        if (raddr != MEM_ADDR_WIDTH'(NUM_NODES - 1)) begin
          raddr <= raddr + MEM_ADDR_WIDTH'(1);
        end
      end
      if (stream_xfer) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= PAD;
            busy_q   <= 1'b1;
            rd_cnt   <= '0;
            xfer_cnt <= '0;
            raddr    <= '0;
          end
        end
        PAD: begin
          if (xfer) state <= STREAM;
        end
        STREAM: begin
          if (last_xfer) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          done_q   <= 1'b0;
          rd_cnt   <= '0;
          xfer_cnt <= '0;
          raddr    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTERNAL_NODE_SENDER_CHECKSUM_EN
  logic [INTERNAL_WIDTH-1:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if ((state == IDLE) && bus.start) begin
      csum <= '0;
    end else if (stream_xfer) begin
      csum <= csum ^ bus.sender_data;
    end
  end

  assign bus.checksum = csum;
`endif

endmodule

// File: doc/internal_node_sender.md
Name: internal_node_sender

Overview:
- Streams the KD-tree internal-node split words from node storage into the register-based internal node tree.
- Acts as the transmitter side of the sender_enable / sender_data write stream that the tree consumes in address order.
- Sits between the node storage (synchronous-read memory) and the tree; the top-level FSM starts it and holds the tree's fsm_enable high while busy is asserted.
- Produces one reserved pad word, then NUM_NODES node words, with receiver backpressure.

Parameters:
- INTERNAL_WIDTH, 22, width of one internal-node word.
- NUM_NODES, 127, internal nodes per tree.
- MEM_ADDR_WIDTH, 7, node-storage address width; must satisfy 2**MEM_ADDR_WIDTH >= NUM_NODES.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE.
- mem_ren  out  1  node-storage read enable.
- mem_raddr  out  MEM_ADDR_WIDTH  node-storage read address.
- mem_rdata  in  INTERNAL_WIDTH  read data, valid exactly 1 cycle after mem_ren.
- receiver_ready  in  1  tree accepts a word this cycle; tie high if the tree never stalls.
- sender_enable  out  1  sender_data is valid.
- sender_data  out  INTERNAL_WIDTH  node word.
- busy  out  1  high from the cycle after start is accepted through the last transfer.
- done  out  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low.
  - All outputs are 0, the FSM is in IDLE, the buffer is empty and all counters are 0.
  - Reset asserted mid-transfer discards everything; no done pulse.
- Transfer rule: a word moves only on a cycle with sender_enable && receiver_ready.
  - While receiver_ready is low, sender_enable and sender_data hold stable.
  - sender_enable never drops without a transfer, except on abort or reset.
- Word order:
  - Word 0 is the pad, sender_data = 0. The receiver's address 0 is reserved and writes no node.
  - Words 1..NUM_NODES are mem[0..NUM_NODES-1], in ascending address order.
- FSM states and transitions:
  - IDLE: on start go to PAD. busy rises next cycle.
  - PAD: sender_enable=1, sender_data=0. The first read (addr 0) is issued in this same cycle. On transfer go to STREAM.
  - STREAM: present the buffer head. After transfer number NUM_NODES (the last node word) go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- Read prefetch:
  - Uses a 2-entry FIFO.
  - A read is issued when (entries + reads in flight) < 2 and the read count is < NUM_NODES.
  - mem_raddr increments per issued read and never wraps past NUM_NODES-1.
  - A FIFO push and pop in the same cycle are both honoured.
- Latency and throughput:
  - Start accepted at cycle T: pad presented at T+1, node0 presented at T+2.
  - With receiver_ready held high, one word per cycle; the last transfer is at T+1+NUM_NODES and done pulses at T+2+NUM_NODES.
- Abort:
  - Any non-IDLE state goes to IDLE next cycle.
  - The FIFO is flushed, any in-flight read data is dropped, and counters are cleared.
  - No done pulse.
  - Abort in IDLE has no effect. If abort and start coincide in IDLE, start wins.
- Start while busy is ignored.

Optional Feature:
- INTERNAL_NODE_SENDER_CHECKSUM_EN: adds output checksum [INTERNAL_WIDTH-1:0].
  - The checksum is the running XOR of all transferred node words; the pad word is excluded.
  - It clears when start is accepted and is stable from the done pulse until the next start.
  - Without the macro there is no port and no logic.

Decomposition:
- Shared package internal_node_pkg holds:
  - INTERNAL_WIDTH and NUM_NODES defaults.
  - The node-count width, clog2(NUM_NODES+1).
  - The sender state enum: IDLE, PAD, STREAM, DONE.
- One sub-module, sender_skid_fifo: 2-entry FIFO with push/pop/flush and full/empty/count outputs.

Test Plan:
- mem[i]=i+1, ready=1, start at cycle 5 -> pad word 0 at cycle 6, words 1..127 on cycles 7..133, done at 134, busy low at 134.
- Same stream with ready toggled 1-0-1-0 -> identical word sequence, sender_data stable on every ready-low cycle, no duplicated or lost word.
- ready held low for 10 cycles during PAD -> mem_ren asserts for at most 2 reads, then stalls; stream resumes correctly.
- abort at the 50th transfer -> IDLE next cycle, no done; a new start resends the pad followed by mem[0] at the head.
- rst_n low mid-stream -> outputs 0 immediately (asynchronous); the next start yields a full correct stream.
- With INTERNAL_NODE_SENDER_CHECKSUM_EN and mem[i]=i+1 -> checksum equals the XOR of 1..127, which is 0x00000 (width 22).
